// File: rtl/demux_seq_pkg.sv
// ============================================================================
// Module      : demux_seq_pkg
// Description : Shared constants and state encoding for the demux sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_seq_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/demux_frame_sequencer_next_set_bit.sv
// ============================================================================
// Module      : next_set_bit
// Description : Finds the lowest set mask bit, or the lowest set bit above cur.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_set_bit
    import demux_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              lowest,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);

    // Scan downward so the last hit written is the lowest qualifying index.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (lowest || (SEL_W'(i) > cur))) begin
                idx   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux_frame_sequencer.sv
// ============================================================================
// Module      : demux_frame_sequencer
// Description : Serialises enabled bits of a word onto a 1-to-8 demux tree.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_frame_sequencer
    import demux_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_CH-1:0] in_data,
    input  logic [NUM_CH-1:0] in_mask,
    output logic              dmx_data,
    output logic [SEL_W-1:0]  dmx_sel,
    output logic              dmx_en,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [3:0] c_HOLD_INIT = 4'(HOLD_CYCLES - 1);

    state_t             r_state, w_state_nx;
    logic [NUM_CH-1:0]  r_word, w_word_nx;
    logic [NUM_CH-1:0]  r_mask, w_mask_nx;
    logic [SEL_W-1:0]   r_ch, w_ch_nx;
    logic [3:0]         r_hold, w_hold_nx;
    logic               w_done_nx;

    logic               r_in_ready, r_dmx_data, r_dmx_en, r_busy, r_frame_done;
    logic [SEL_W-1:0]   r_dmx_sel;
    logic               w_in_ready_nx, w_dmx_data_nx, w_dmx_en_nx, w_busy_nx;
    logic [SEL_W-1:0]   w_dmx_sel_nx;

    logic               w_lowest, w_found;
    logic [SEL_W-1:0]   w_idx;
    logic [NUM_CH-1:0]  w_search_mask;

    // One search unit serves both the accept (lowest bit) and each advance.
    assign w_lowest      = (r_state == IDLE);
    assign w_search_mask = w_lowest ? in_mask : r_mask;

    next_set_bit u_next_set_bit (
        .mask   (w_search_mask),
        .cur    (r_ch),
        .lowest (w_lowest),
        .idx    (w_idx),
        .found  (w_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_mask       <= '0;
            r_ch         <= '0;
            r_hold       <= '0;
            r_in_ready   <= 1'b0;
            r_dmx_data   <= 1'b0;
            r_dmx_sel    <= '0;
            r_dmx_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_word       <= w_word_nx;
            r_mask       <= w_mask_nx;
            r_ch         <= w_ch_nx;
            r_hold       <= w_hold_nx;
            r_in_ready   <= w_in_ready_nx;
            r_dmx_data   <= w_dmx_data_nx;
            r_dmx_sel    <= w_dmx_sel_nx;
            r_dmx_en     <= w_dmx_en_nx;
            r_busy       <= w_busy_nx;
            r_frame_done <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_word_nx  = r_word;
        w_mask_nx  = r_mask;
        w_ch_nx    = r_ch;
        w_hold_nx  = r_hold;
        w_done_nx  = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_word_nx = in_data;
                    w_mask_nx = in_mask;
                    if (w_found) begin
                        w_state_nx = SCAN;
                        w_ch_nx    = w_idx;
                        w_hold_nx  = c_HOLD_INIT;
                    end else begin
                        w_done_nx  = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (r_hold != 4'd0) begin
                    w_hold_nx = r_hold - 4'd1;
                end else if (w_found) begin
                    w_ch_nx   = w_idx;
                    w_hold_nx = c_HOLD_INIT;
                end else begin
                    w_state_nx = IDLE;
                    w_done_nx  = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they align with it.
    always_comb begin
        w_in_ready_nx = (w_state_nx == IDLE);
        w_busy_nx     = (w_state_nx == SCAN);
        w_dmx_en_nx   = (w_state_nx == SCAN);
        w_dmx_sel_nx  = (w_state_nx == SCAN) ? w_ch_nx : r_dmx_sel;
        w_dmx_data_nx = (w_state_nx == SCAN) ? w_word_nx[w_ch_nx] : 1'b0;
    end

    assign in_ready   = r_in_ready;
    assign dmx_data   = r_dmx_data;
    assign dmx_sel    = r_dmx_sel;
    assign dmx_en     = r_dmx_en;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire
